// File: rtl/aes_round_scheduler.sv
// Iterative AES-128 round sequencer: arbitrates one shared combinational round unit between host (A) and DMA (B).
// Define AES_ROUND_RR_EN for round-robin tie-breaking; otherwise A has fixed priority over B.
module aes_round_scheduler #(
    parameter int DATA_W     = 128,
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [DATA_W-1:0] rnd_state,
    output logic [IDX_W-1:0]  rnd_idx,
    output logic              rnd_final,
    input  logic [DATA_W-1:0] rnd_result,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_id,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t              fsm;
    logic [DATA_W-1:0] state_reg;
    logic              id_reg;
    logic              grant_a;
    logic              grant_b;
    logic              last_round;
`ifdef AES_ROUND_RR_EN
    logic              last_id;
`endif

    // Grants are combinational so a requester sees ready in the same cycle it is accepted.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (fsm == IDLE && !rst) begin
`ifdef AES_ROUND_RR_EN
            grant_a = a_valid & (~b_valid | last_id);
            grant_b = b_valid & ~grant_a;
`else
            grant_a = a_valid;
            grant_b = b_valid & ~a_valid;
`endif
        end
    end

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign last_round = (rnd_idx == IDX_W'(NUM_ROUNDS));
    assign rnd_state  = state_reg;
    assign rnd_final  = (fsm == ROUND) && last_round;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            state_reg <= '0;
            id_reg    <= 1'b0;
            rnd_idx   <= '0;
            out_data  <= '0;
            out_id    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef AES_ROUND_RR_EN
            last_id   <= 1'b1;
`endif
        end else begin
            case (fsm)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        state_reg <= grant_b ? b_data : a_data;
                        id_reg    <= grant_b;
                        rnd_idx   <= '0;
                        busy      <= 1'b1;
                        fsm       <= ROUND;
`ifdef AES_ROUND_RR_EN
                        last_id   <= grant_b;
`endif
                    end
                end
                ROUND: begin
                    state_reg <= rnd_result;
                    if (last_round) begin
                        // Index parks at 0 so the round-unit inputs stay defined outside ROUND.
                        rnd_idx   <= '0;
                        out_valid <= 1'b1;
                        out_data  <= rnd_result;
                        out_id    <= id_reg;
                        fsm       <= DONE;
                    end else begin
                        rnd_idx <= rnd_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        fsm       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Bench for aes_round_scheduler: behavioural AES-128 round unit plus a per-cycle protocol model.
module tb_aes_round_scheduler;

    localparam int DW = 128;
    localparam int NR = 10;
    localparam int IW = 4;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid = 1'b0;
    logic [DW-1:0] a_data = '0;
    logic          a_ready;
    logic          b_valid = 1'b0;
    logic [DW-1:0] b_data = '0;
    logic          b_ready;
    logic [DW-1:0] rnd_state;
    logic [IW-1:0] rnd_idx;
    logic          rnd_final;
    logic [DW-1:0] rnd_result;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_id;
    logic          out_ready = 1'b1;
    logic          busy;

    int vec  = 0;
    int miss = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk   [11];
    logic [31:0]  w    [44];

    always #5 clk = ~clk;

    aes_round_scheduler #(.DATA_W(DW), .NUM_ROUNDS(NR), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .rnd_state(rnd_state), .rnd_idx(rnd_idx), .rnd_final(rnd_final),
        .rnd_result(rnd_result),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_ready(out_ready), .busy(busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] x, y, p;
        x = a_in; y = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // One AES round exactly as the external round unit would compute it.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [3:0] idx);
        logic [7:0]   sb [16];
        logic [7:0]   t  [16];
        logic [7:0]   m  [16];
        logic [127:0] r;
        if (idx > 4'(NR)) return s;
        if (idx == 4'd0) return s ^ rk[0];
        for (int i = 0; i < 16; i++) sb[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                t[4*c+rr] = sb[4*((c+rr)%4)+rr];
        for (int c = 0; c < 4; c++) begin
            if (idx != 4'(NR)) begin
                m[4*c]   = gmul(t[4*c],8'h02) ^ gmul(t[4*c+1],8'h03) ^ t[4*c+2] ^ t[4*c+3];
                m[4*c+1] = t[4*c] ^ gmul(t[4*c+1],8'h02) ^ gmul(t[4*c+2],8'h03) ^ t[4*c+3];
                m[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],8'h02) ^ gmul(t[4*c+3],8'h03);
                m[4*c+3] = gmul(t[4*c],8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],8'h02);
            end else begin
                for (int rr = 0; rr < 4; rr++) m[4*c+rr] = t[4*c+rr];
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = m[i];
        return r ^ rk[idx];
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] p);
        logic [127:0] s;
        s = p;
        for (int r = 0; r <= NR; r++) s = aes_round(s, 4'(r));
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    assign rnd_result = aes_round(rnd_state, rnd_idx);

    // Protocol model: phase 0 idle, 1 rounds, 2 result waiting for the consumer.
    int           m_phase = 0;
    logic [3:0]   m_cnt   = '0;
    logic [127:0] m_st    = '0;
    logic [127:0] m_exp   = '0;
    logic         m_id    = 1'b0;
    logic         m_clean = 1'b1;
    logic         m_last  = 1'b1;
    logic         out_log [$];

    always @(negedge clk) begin
        logic ea, eb;
        if (rst) begin
            chk("rst_a_ready", 128'(a_ready), 128'(1'b0));
            chk("rst_b_ready", 128'(b_ready), 128'(1'b0));
            m_phase = 0; m_clean = 1'b1; m_last = 1'b1;
        end else begin
            case (m_phase)
                0: begin
`ifdef AES_ROUND_RR_EN
                    ea = a_valid && (!b_valid || m_last);
`else
                    ea = a_valid;
`endif
                    eb = b_valid && !ea;
                    chk("idle_a_ready", 128'(a_ready), 128'(ea));
                    chk("idle_b_ready", 128'(b_ready), 128'(eb));
                    chk("idle_busy", 128'(busy), 128'(1'b0));
                    chk("idle_out_valid", 128'(out_valid), 128'(1'b0));
                    chk("idle_rnd_idx", 128'(rnd_idx), 128'(0));
                    if (m_clean) begin
                        chk("clean_out_data", out_data, 128'(0));
                        chk("clean_out_id", 128'(out_id), 128'(1'b0));
                    end
                    if (ea || eb) begin
                        m_id = eb; m_st = eb ? b_data : a_data;
                        m_exp = aes_encrypt(m_st);
                        m_cnt = '0; m_phase = 1; m_clean = 1'b0; m_last = eb;
                    end
                end
                1: begin
                    chk("round_readies", 128'({a_ready, b_ready}), 128'(0));
                    chk("round_busy", 128'(busy), 128'(1'b1));
                    chk("round_out_valid", 128'(out_valid), 128'(1'b0));
                    chk("round_idx", 128'(rnd_idx), 128'(m_cnt));
                    chk("round_final", 128'(rnd_final), 128'(m_cnt == 4'(NR)));
                    chk("round_state", rnd_state, m_st);
                    m_st = aes_round(m_st, m_cnt);
                    m_cnt = m_cnt + 4'd1;
                    if (m_cnt > 4'(NR)) m_phase = 2;
                end
                default: begin
                    chk("done_out_valid", 128'(out_valid), 128'(1'b1));
                    chk("done_out_data", out_data, m_exp);
                    chk("done_out_id", 128'(out_id), 128'(m_id));
                    chk("done_busy", 128'(busy), 128'(1'b1));
                    chk("done_readies", 128'({a_ready, b_ready}), 128'(0));
                    if (out_ready) begin
                        out_log.push_back(m_id);
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    task automatic send(input logic port, input logic [127:0] d);
        int k;
        k = 0;
        if (port) begin b_data = d; b_valid = 1'b1; end
        else      begin a_data = d; a_valid = 1'b1; end
        @(negedge clk);
        while (!(port ? b_ready : a_ready) && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("grant_wait", 128'(port ? b_ready : a_ready), 128'(1'b1));
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int           n;
        logic         ga, gb;
        int           grants;
        logic [127:0] held;
        logic [7:0]   inv, rc, v;
        logic [31:0]  tmp;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            v = inv;
            sbox[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
        end
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]] ^ rc, sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        chk("pin_sbox_00", 128'(sbox[0]), 128'(8'h63));
        chk("pin_sbox_53", 128'(sbox[8'h53]), 128'(8'hed));
        chk("pin_rk10", rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("pin_model_ct", aes_encrypt(PT), CT);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 128'(busy), 128'(1'b0));
        chk("reset_out", {out_valid, out_id, out_data[125:0]}, 128'(0));

        // Golden vector through A
        send(1'b0, PT);
        wait_valid(n);
        chk("golden_latency", 128'(n), 128'(11));
        chk("golden_ct", out_data, CT);
        chk("golden_id", 128'(out_id), 128'(1'b0));
        @(posedge clk); #1;
        chk("golden_back_idle", 128'(busy), 128'(1'b0));

        // Lone B
        send(1'b1, PT);
        wait_valid(n);
        chk("loneb_latency", 128'(n), 128'(11));
        chk("loneb_ct", out_data, CT);
        chk("loneb_id", 128'(out_id), 128'(1'b1));
        @(posedge clk); #1;

        // Tie held across two blocks
        out_log.delete();
        a_data = rand128(); b_data = rand128();
        a_valid = 1'b1; b_valid = 1'b1;
        grants = 0; n = 0;
        while (grants < 2 && n < 200) begin
            @(negedge clk); ga = a_ready; gb = b_ready;
            @(posedge clk); #1;
            n++;
            if (ga) a_data = rand128();
            if (gb) b_data = rand128();
            if (ga || gb) grants++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        n = 0;
        while (out_log.size() < 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("tie_count", 128'(out_log.size()), 128'(2));
        chk("tie_first_id", 128'(out_log.size() > 0 ? out_log[0] : 1'bx), 128'(1'b0));
`ifdef AES_ROUND_RR_EN
        chk("tie_second_id", 128'(out_log.size() > 1 ? out_log[1] : 1'bx), 128'(1'b1));
`else
        chk("tie_second_id", 128'(out_log.size() > 1 ? out_log[1] : 1'bx), 128'(1'b0));
`endif

        // Backpressure for 20 cycles with a competing request pending
        out_ready = 1'b0;
        send(1'b0, rand128());
        wait_valid(n);
        chk("bp_latency", 128'(n), 128'(11));
        held = out_data;
        a_data = rand128(); a_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("bp_data_stable", out_data, held);
        chk("bp_busy", 128'(busy), 128'(1'b1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", 128'(busy), 128'(1'b0));
        chk("bp_regrant", 128'(a_ready), 128'(1'b1));
        @(posedge clk); #1;
        a_valid = 1'b0;
        wait_valid(n);
        @(posedge clk); #1;

        // Reset in the middle of a block
        send(1'b0, rand128());
        n = 0;
        while (rnd_idx != 4'd5 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_idx5", 128'(rnd_idx), 128'(5));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_outs", {busy, out_valid, out_id, rnd_final, rnd_idx, out_data[115:0]}, 128'(0));
        chk("mid_rst_data", out_data, 128'(0));
        send(1'b1, PT);
        wait_valid(n);
        chk("mid_rst_ct", out_data, CT);
        @(posedge clk); #1;

        // Randomised traffic with random consumer stalls
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk); ga = a_ready; gb = b_ready;
            @(posedge clk); #1;
            if (a_valid && ga) begin
                a_valid = ($urandom_range(0, 1) == 1); a_data = rand128();
            end else if (!a_valid) begin
                if ($urandom_range(0, 3) == 0) begin a_valid = 1'b1; a_data = rand128(); end
            end else if ($urandom_range(0, 31) == 0) a_valid = 1'b0;
            if (b_valid && gb) begin
                b_valid = ($urandom_range(0, 1) == 1); b_data = rand128();
            end else if (!b_valid) begin
                if ($urandom_range(0, 3) == 0) begin b_valid = 1'b1; b_data = rand128(); end
            end else if ($urandom_range(0, 31) == 0) b_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
        end

        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_idle", 128'(busy), 128'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/aes_round_scheduler.md
Name: aes_round_scheduler

Overview:
- Iterative controller that sequences a shared, purely combinational single-round AES-128 encryption datapath (the external round unit) through initial AddRoundKey plus rounds 1..NUM_ROUNDS.
- Arbitrates that one round unit between two block requesters (port A: host, port B: DMA).
- Returns each ciphertext with the winning requester's ID over a valid/ready output.
- One block in flight at a time; no pipelining.

Parameters:
- DATA_W, 128, block width in bits.
- NUM_ROUNDS, 10, number of full rounds after round 0 (AES-128).
- IDX_W, 4, width of the round index; must satisfy 2^IDX_W > NUM_ROUNDS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  requester A block valid.
- a_data  input  DATA_W  requester A plaintext.
- a_ready  output  1  requester A accepted this cycle.
- b_valid  input  1  requester B block valid.
- b_data  input  DATA_W  requester B plaintext.
- b_ready  output  1  requester B accepted this cycle.
- rnd_state  output  DATA_W  current state presented to the round unit.
- rnd_idx  output  IDX_W  round number 0..NUM_ROUNDS; selects the round key.
- rnd_final  output  1  high when rnd_idx==NUM_ROUNDS (omit MixColumns).
- rnd_result  input  DATA_W  combinational round-unit result for rnd_state/rnd_idx.
- out_valid  output  1  ciphertext valid.
- out_data  output  DATA_W  ciphertext.
- out_id  output  1  0 = requester A, 1 = requester B.
- out_ready  input  1  consumer accepts.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: on any clk edge with rst=1, FSM goes to IDLE and the following clear to 0 regardless of the current state: state_reg, rnd_idx, out_data, out_id, out_valid, a_ready, b_ready, busy. rst mid-ROUND abandons the block; no output is produced for it.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - a_ready/b_ready are combinational grants, at most one high.
  - Default arbitration is fixed priority A over B: a_ready=a_valid; b_ready=b_valid & ~a_valid.
  - On a grant edge: state_reg<=granted data, id_reg<=granted id, rnd_idx<=0, next state ROUND.
- ROUND:
  - Both readies are 0.
  - Each edge: state_reg<=rnd_result.
  - If rnd_idx==NUM_ROUNDS, go to DONE; otherwise rnd_idx<=rnd_idx+1.
  - rnd_state=state_reg; rnd_final=(rnd_idx==NUM_ROUNDS).
- DONE:
  - out_valid=1; out_data=state_reg; out_id=id_reg.
  - out_data/out_id hold stable while out_ready=0, indefinitely.
  - On out_valid&out_ready edge, go to IDLE.
- Latency:
  - Acceptance edge E0; rounds evaluated on edges E1..E(NUM_ROUNDS+1).
  - out_valid first high after edge E(NUM_ROUNDS+1), i.e. 11 cycles for default.
  - Earliest next acceptance is the cycle after the output handshake, giving minimum 13 cycles per block.
- rnd_state, rnd_idx, rnd_final are don't-care outside ROUND, but must be driven (no X); use state_reg and 0.
- rnd_idx never exceeds NUM_ROUNDS; no wrap.
- Simultaneous a_valid and b_valid in IDLE: exactly one is granted per the arbitration rule; the loser's valid/data must stay held by the requester, and it is granted on a later IDLE.
- A requester dropping valid before its grant is legal; no state changes.

Optional Feature:
- Macro AES_ROUND_RR_EN.
- Defined:
  - Round-robin arbitration with a 1-bit last_id register, reset to 1 (so A wins the first tie).
  - On a tie, the requester not equal to last_id is granted.
  - last_id updates on each grant.
  - A lone valid is always granted.
- Undefined:
  - Fixed priority A over B as above; no last_id register.

Test Plan:
- Golden vector: bench round-unit model keyed 000102030405060708090a0b0c0d0e0f; a_data=00112233445566778899aabbccddeeff, out_ready=1 → out_valid after exactly 11 cycles, out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_id=0.
- Round sequencing: during the block, rnd_idx steps 0,1,...,10 on consecutive cycles → rnd_final=1 only at idx 10; a_ready=b_ready=0 throughout.
- Tie arbitration: a_valid=b_valid=1 held for two blocks.
  - Default build: outputs in order out_id=0 then 0 while A is held.
  - AES_ROUND_RR_EN build: out_id 0 then 1.
- Backpressure: out_ready=0 for 20 cycles after out_valid → out_data/out_id stable, busy=1, no grants; out_ready=1 → return to IDLE next edge, grant possible the following cycle.
- Reset mid-operation: rst=1 at rnd_idx=5 for one cycle → next cycle all outputs 0, FSM IDLE; a new block then completes with the correct ciphertext.
- Lone B: b_valid only, b_data=00112233445566778899aabbccddeeff → b_ready=1 the same cycle, out_id=1, same ciphertext as the golden vector.
